axi_read_slave: RTL

AXI_READ_SLAVE -- requirements
Module: axi_read_slave

---
 rtl/axi_read_slave.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_slave.sv
// -----------------------------------------------------------------------------
// axi_read_slave
//
// AXI read-channel responder backed by an internal DEPTH x WIDTH word memory.
// Accepts one read burst at a time (IDLE -> BURST -> IDLE) and returns
// ARLEN+1 beats. RVALID rises one cycle after the AR handshake, and beats
// stream at full rate while RREADY is high. The memory is filled through a
// backdoor write port that is live in every state, including reset, and is
// never cleared.
//
// Optional feature macro: AXI_RD_ERRCHK_EN
//   Defined   : malformed requests answer SLVERR on every beat; beats that fall
//               outside the memory answer DECERR. Error beats carry RDATA = 0.
//   Undefined : no checking, RRESP is always OKAY, ARBURST=11 behaves as INCR
//               and addresses wrap modulo DEPTH words.
//
// Ports
//   i_clk                    rising-edge clock
//   i_reset                  synchronous, active-high reset
//   i_arvalid / o_arready    read-address handshake
//   i_arid, i_araddr         request ID and byte address
//   i_arlen                  beats - 1
//   i_arsize                 log2(bytes per beat)
//   i_arburst                00 FIXED, 01 INCR, 10 WRAP
//   o_rvalid / i_rready      read-data handshake
//   o_rid, o_rdata, o_rresp  beat ID, data and response
//   o_rlast                  final beat of the burst
//   i_mem_we, i_mem_addr,
//   i_mem_wdata              backdoor memory write (word index)
// -----------------------------------------------------------------------------
module axi_read_slave #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 3,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  // Read-address channel
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [WIDTH/8-1:0]       i_arid,
  input  logic [WIDTH-1:0]         i_araddr,
  input  logic [WIDTH/8-1:0]       i_arlen,
  input  logic [SIZE-1:0]          i_arsize,
  input  logic [SIZE-2:0]          i_arburst,
  // Read-data channel
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [WIDTH/8-1:0]       o_rid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [SIZE-2:0]          o_rresp,
  output logic                     o_rlast,
  // Backdoor preload
  input  logic                     i_mem_we,
  input  logic [$clog2(DEPTH)-1:0] i_mem_addr,
  input  logic [WIDTH-1:0]         i_mem_wdata
);

  localparam int unsigned AW     = $clog2(DEPTH);
  // Byte-address to word-index shift (2 for 32-bit words).
  localparam int unsigned BSHIFT = $clog2(WIDTH / 8);

  localparam logic [SIZE-2:0] BurstFixed = (SIZE - 1)'(0);
  localparam logic [SIZE-2:0] BurstWrap  = (SIZE - 1)'(2);
  localparam logic [SIZE-2:0] RespOkay   = (SIZE - 1)'(0);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH/8-1:0] r_len;
  logic [SIZE-1:0]    r_size;
  logic [SIZE-2:0]    r_burst;
  logic [WIDTH/8-1:0] r_beat;

  logic [WIDTH/8-1:0] r_rid;
  logic [WIDTH-1:0]   r_rdata;
  logic [SIZE-2:0]    r_rresp;
  logic               r_rlast;

  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_last_beat;
  logic               w_load_en;
  logic [WIDTH-1:0]   w_addr_next;
  logic [WIDTH-1:0]   w_load_addr;
  logic               w_load_last;
  logic [WIDTH-1:0]   w_mem_rd;
  logic [WIDTH-1:0]   w_load_data;
  logic [SIZE-2:0]    w_load_resp;

  // Address of the beat after `addr` for the captured burst type.
  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0]   addr,
                                                 input logic [WIDTH/8-1:0] len,
                                                 input logic [SIZE-1:0]    size,
                                                 input logic [SIZE-2:0]    burst);
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] mask;
    step = WIDTH'(1) << size;
    span = (WIDTH'(len) + WIDTH'(1)) << size;
    mask = span - WIDTH'(1);
    if (burst == BurstFixed) begin
      next_addr = addr;
    end else if (burst == BurstWrap) begin
      next_addr = (addr & ~mask) | ((addr + step) & mask);
    end else begin
      // INCR, and the reserved encoding when it is not rejected.
      next_addr = addr + step;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    case (r_state)
      StIdle: begin
        o_arready = 1'b1;
        if (i_arvalid) begin
          w_state_next = StBurst;
        end
      end
      StBurst: begin
        o_rvalid = 1'b1;
        if (i_rready && w_last_beat) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat sequencing
  // ---------------------------------------------------------------------------
  assign w_ar_hs     = i_arvalid && o_arready;
  assign w_r_hs      = o_rvalid && i_rready;
  assign w_last_beat = (r_beat == r_len);
  assign w_addr_next = next_addr(r_addr, r_len, r_size, r_burst);

  // The output register is loaded either with the first beat (straight from
  // the AR channel) or with the following beat when the current one is taken.
  assign w_load_en   = w_ar_hs || (w_r_hs && !w_last_beat);
  assign w_load_addr = (r_state == StIdle) ? i_araddr : w_addr_next;
  assign w_load_last = (r_state == StIdle) ? (i_arlen == '0)
                                           : ((r_beat + (WIDTH / 8)'(1)) == r_len);

  // Whole-word read; narrow beats simply return the containing word.
  assign w_mem_rd = r_mem[w_load_addr[BSHIFT +: AW]];

`ifdef AXI_RD_ERRCHK_EN
  localparam logic [SIZE-2:0]    BurstRsvd  = (SIZE - 1)'(3);
  localparam logic [SIZE-2:0]    RespSlverr = (SIZE - 1)'(2);
  localparam logic [SIZE-2:0]    RespDecerr = (SIZE - 1)'(3);
  localparam logic [SIZE-1:0]    MaxSize    = SIZE'(BSHIFT);
  localparam longint unsigned    MemBytes   = longint'(DEPTH) * longint'(WIDTH / 8);

  logic r_slverr;
  logic w_slverr_in;
  logic w_load_slverr;
  logic w_load_decerr;

  // Request-level errors are decided once at the AR handshake and stick for
  // every beat of the burst.
  assign w_slverr_in = (i_arburst == BurstRsvd) ||
                       (i_arsize > MaxSize) ||
                       ((i_arburst == BurstWrap) && !(i_arlen inside {1, 3, 7, 15}));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slverr <= 1'b0;
    end else if (w_ar_hs) begin
      r_slverr <= w_slverr_in;
    end
  end

  assign w_load_slverr = (r_state == StIdle) ? w_slverr_in : r_slverr;
  // Out-of-range is judged per beat, so a burst may cross into DECERR midway.
  assign w_load_decerr = 64'(w_load_addr) >= MemBytes;

  assign w_load_resp = w_load_slverr ? RespSlverr :
                       w_load_decerr ? RespDecerr : RespOkay;
  assign w_load_data = (w_load_slverr || w_load_decerr) ? '0 : w_mem_rd;
`else
  logic w_unused_addr;

  // Address bits outside the word index are ignored: accesses wrap.
  assign w_unused_addr = ^{w_load_addr[WIDTH-1:BSHIFT+AW], w_load_addr[BSHIFT-1:0]};

  assign w_load_resp = RespOkay;
  assign w_load_data = w_mem_rd;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
      r_rlast <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_addr  <= i_araddr;
        r_len   <= i_arlen;
        r_size  <= i_arsize;
        r_burst <= i_arburst;
        r_beat  <= '0;
        r_rid   <= i_arid;
      end else if (w_r_hs && !w_last_beat) begin
        r_beat <= r_beat + (WIDTH / 8)'(1);
        r_addr <= w_addr_next;
      end

      if (w_load_en) begin
        r_rdata <= w_load_data;
        r_rresp <= w_load_resp;
        r_rlast <= w_load_last;
      end else if (w_r_hs) begin
        // Final beat accepted.
        r_rlast <= 1'b0;
      end
    end
  end

  // Backdoor port: no reset, so contents survive reset and writes land even
  // while reset is asserted. A same-cycle read above sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_mem_we) begin
      r_mem[i_mem_addr] <= i_mem_wdata;
    end
  end

  assign o_rid   = r_rid;
  assign o_rdata = r_rdata;
  assign o_rresp = r_rresp;
  assign o_rlast = r_rlast;

endmodule
